cell_bist_seq: RTL and testbench

- Built-in self-test sequencer for the high-speed cell test chip.
- Sits directly upstream of a bank of library cells under test (CUT). It drives the CUT input pins with stimulus vectors.
- Sits downstream of the CUT outputs. It samples them, compares each against an expected value from a golden model, and reports pass/fail, an error count and the first failing vector index.

---
 rtl/cell_bist_seq.sv | 196 +++++++++++++++++++
 tb/tb_cell_bist_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_bist_seq.sv
// cell_bist_seq: BIST sequencer - drives CUT stimulus, compares RESP against EXP, reports pass/fail and the first failing vector.
// Latency: first vector on STIM in the cycle after START; each vector's response is compared PIPE cycles after it appears.
// Backpressure: none; START while BUSY is ignored. Optional MISR signature port SIG when CELL_BIST_SEQ_MISR_EN is defined.
module cell_bist_seq #(
  parameter int NIN  = 4,
  parameter int NOUT = 8,
  parameter int PIPE = 2,
  parameter int ERRW = 16
) (
  input  logic              CLK,
  input  logic              RESET_B,
  input  logic              START,
  input  logic              MODE,
  input  logic [15:0]       COUNT,
  output logic [NIN-1:0]    STIM,
  input  logic [NOUT-1:0]   RESP,
  input  logic [NOUT-1:0]   EXP,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [ERRW-1:0]   ERR_CNT,
  output logic [15:0]       FIRST_FAIL
`ifdef CELL_BIST_SEQ_MISR_EN
  ,
  output logic [NOUT-1:0]   SIG
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Fibonacci feedback taps, shifting right with feedback into the MSB.
  // Polynomial x^n + x^k + ... + 1 feeds back bits 0 and (n-k).
  localparam logic [7:0] LFSR_TAPS8 = (NIN == 5) ? 8'h05 :
                                      (NIN == 8) ? 8'h1D : 8'h03;
  localparam logic [NIN-1:0] LFSR_TAPS = LFSR_TAPS8[NIN-1:0];
  localparam logic [3:0]     DCNT_LAST = 4'(PIPE - 1);
  localparam logic [15:0]    EXH_LAST  = 16'((1 << NIN) - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_mode;
  logic [15:0]       r_last;
  logic [15:0]       r_vidx;
  logic [NIN-1:0]    r_stim;
  logic [3:0]        r_dcnt;
  logic [ERRW-1:0]   r_err;
  logic [15:0]       r_first;
  logic              r_fail_seen;
  logic [PIPE-1:0]   r_vld;
  logic [15:0]       r_pidx [PIPE];

  logic              w_start_ok;
  logic              w_zero_run;
  logic              w_fb;
  logic [NIN-1:0]    w_stim_nxt;
  logic              w_cmp_vld;
  logic [15:0]       w_cmp_idx;
  logic              w_mismatch;

  assign w_start_ok = START && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_zero_run = MODE && (COUNT == 16'd0);
  assign w_fb       = ^(r_stim & LFSR_TAPS);
  assign w_stim_nxt = r_mode ? {w_fb, r_stim[NIN-1:1]}
                             : r_stim + {{(NIN-1){1'b0}}, 1'b1};
  assign w_cmp_vld  = r_vld[PIPE-1];
  assign w_cmp_idx  = r_pidx[PIPE-1];
  assign w_mismatch = (RESP != EXP);

  assign STIM       = r_stim;
  assign ERR_CNT    = r_err;
  assign FIRST_FAIL = r_first;

  // State register.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    w_state_nxt = r_state;
    BUSY        = 1'b0;
    DONE        = 1'b0;
    PASS        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_state_nxt = w_zero_run ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        BUSY = 1'b1;
        if (r_vidx == r_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        BUSY = 1'b1;
        if (r_dcnt == DCNT_LAST) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        DONE = 1'b1;
        PASS = (r_err == '0);
        if (w_start_ok) w_state_nxt = w_zero_run ? S_DRAIN : S_RUN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Drain timer: counts cycles spent in DRAIN, parked at zero otherwise.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      r_dcnt <= '0;
    end else if (r_state == S_DRAIN) begin
      r_dcnt <= r_dcnt + 4'd1;
    end else begin
      r_dcnt <= '0;
    end
  end

  // Valid/index pipe: each RUN cycle's vector enters at the end of that cycle
  // and reaches the last stage when its response is present on RESP/EXP.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      r_vld <= '0;
      for (int i = 0; i < PIPE; i++) r_pidx[i] <= '0;
    end else begin
      r_vld[0]  <= (r_state == S_RUN);
      r_pidx[0] <= r_vidx;
      for (int i = 1; i < PIPE; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_pidx[i] <= r_pidx[i-1];
      end
    end
  end

  // Run setup, vector generation and result accumulation.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      r_mode      <= 1'b0;
      r_last      <= '0;
      r_vidx      <= '0;
      r_stim      <= '0;
      r_err       <= '0;
      r_first     <= '0;
      r_fail_seen <= 1'b0;
    end else if (w_start_ok) begin
      r_mode      <= MODE;
      r_last      <= MODE ? (COUNT - 16'd1) : EXH_LAST;
      r_vidx      <= '0;
      r_stim      <= MODE ? {NIN{1'b1}} : '0;
      r_err       <= '0;
      r_first     <= '0;
      r_fail_seen <= 1'b0;
    end else begin
      // STIM holds the last vector once the final one has been issued.
      if ((r_state == S_RUN) && (r_vidx != r_last)) begin
        r_stim <= w_stim_nxt;
        r_vidx <= r_vidx + 16'd1;
      end
      if (w_cmp_vld && w_mismatch) begin
        if (r_err != '1) r_err <= r_err + {{(ERRW-1){1'b0}}, 1'b1};
        if (!r_fail_seen) begin
          r_first     <= w_cmp_idx;
          r_fail_seen <= 1'b1;
        end
      end
    end
  end

`ifdef CELL_BIST_SEQ_MISR_EN
  localparam logic [NOUT-1:0] MISR_TAPS = (NOUT < 3) ? NOUT'(1) : NOUT'(5);

  logic [NOUT-1:0] r_sig;
  logic [NOUT-1:0] w_sig_rot;

  assign w_sig_rot = (r_sig << 1) | (r_sig >> (NOUT - 1));
  assign SIG       = r_sig;

  // MISR absorbs RESP on every compare cycle; no compares happen in DONE, so it freezes there.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      r_sig <= '0;
    end else if (w_start_ok) begin
      r_sig <= '0;
    end else if (w_cmp_vld) begin
      r_sig <= w_sig_rot ^ RESP ^ (r_sig[NOUT-1] ? MISR_TAPS : '0);
    end
  end
`endif

endmodule

// File: tb/tb_cell_bist_seq.sv
// Bench for cell_bist_seq: table-driven runs, randomized runs against a reference model,
// plus hand sequences for ERR_CNT saturation with ignored mid-run START and mid-run reset.
module tb_cell_bist_seq;
  localparam int NIN  = 4;
  localparam int NOUT = 8;
  localparam int PIPE = 2;

  localparam logic [3:0] LFSR_SEQ [15] = '{4'hF, 4'h7, 4'h3, 4'h1, 4'h8, 4'h4, 4'h2, 4'h9,
                                           4'hC, 4'h6, 4'hB, 4'h5, 4'hA, 4'hD, 4'hE};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic            rst_n, start, mode;
  logic [15:0]     count;
  logic [NIN-1:0]  stim;
  logic [NOUT-1:0] resp, exp_v;
  logic            busy, done, pass;
  logic [15:0]     err_cnt, first_fail;
`ifdef CELL_BIST_SEQ_MISR_EN
  logic [NOUT-1:0] sig;
`endif

  // Saturation instance (ERRW = 2)
  logic            rst2_n, start2, mode2;
  logic [15:0]     count2;
  logic [NIN-1:0]  stim2;
  logic [NOUT-1:0] resp2, exp2;
  logic            busy2, done2, pass2;
  logic [1:0]      err2;
  logic [15:0]     ff2;
`ifdef CELL_BIST_SEQ_MISR_EN
  logic [NOUT-1:0] sig2;
`endif

  cell_bist_seq #(.NIN(NIN), .NOUT(NOUT), .PIPE(PIPE), .ERRW(16)) u_dut (
    .CLK(clk), .RESET_B(rst_n), .START(start), .MODE(mode), .COUNT(count),
    .STIM(stim), .RESP(resp), .EXP(exp_v), .BUSY(busy), .DONE(done), .PASS(pass),
    .ERR_CNT(err_cnt), .FIRST_FAIL(first_fail)
`ifdef CELL_BIST_SEQ_MISR_EN
    , .SIG(sig)
`endif
  );

  cell_bist_seq #(.NIN(NIN), .NOUT(NOUT), .PIPE(PIPE), .ERRW(2)) u_sat (
    .CLK(clk), .RESET_B(rst2_n), .START(start2), .MODE(mode2), .COUNT(count2),
    .STIM(stim2), .RESP(resp2), .EXP(exp2), .BUSY(busy2), .DONE(done2), .PASS(pass2),
    .ERR_CNT(err2), .FIRST_FAIL(ff2)
`ifdef CELL_BIST_SEQ_MISR_EN
    , .SIG(sig2)
`endif
  );

  // CUT model: PIPE register stages from STIM, response = {v, ~v}.
  logic [NIN-1:0] cut_d1, cut_d2;
  always @(posedge clk) begin
    cut_d1 <= stim;
    cut_d2 <= cut_d1;
  end
  assign resp = {cut_d2, ~cut_d2};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] golden(input logic [3:0] v);
    return {v, ~v};
  endfunction

  function automatic logic [3:0] exp_vec(input logic m, input int i);
    logic [3:0] t;
    if (m) t = LFSR_SEQ[i % 15];
    else   t = 4'(i);
    return t;
  endfunction

  // Reference model: errors = injected mismatches among issued vectors.
  task automatic ref_model(input logic m, input logic [15:0] cnt, input logic [63:0] mask,
                           output int e_err, output int e_first, output logic e_pass);
    int n;
    n = m ? int'(cnt) : (1 << NIN);
    e_err = 0;
    e_first = 0;
    for (int i = n - 1; i >= 0; i--) begin
      if (mask[i]) begin
        e_err++;
        e_first = i;
      end
    end
    e_pass = (e_err == 0);
  endtask

  // One full run on the main instance; call at posedge+1.
  task automatic run(input string name, input logic m, input logic [15:0] cnt, input logic [63:0] mask,
                     input int e_err, input int e_first, input logic e_pass);
    int  n, c, bcnt;
    bit  seen;
    n = m ? int'(cnt) : (1 << NIN);
    bcnt = 0;
    seen = 0;
    c = 0;
    mode = m;
    count = cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({name, ":busy_first"}, busy, 1'b1);
    while (!seen && c < n + PIPE + 8) begin
      if (c >= PIPE && c - PIPE < n)
        exp_v = golden(exp_vec(m, c - PIPE)) ^ {7'b0, mask[c - PIPE]};
      else
        exp_v = '0;
      if (c < n) chk($sformatf("%s:stim%0d", name, c), stim, exp_vec(m, c));
      if (done) begin
        seen = 1;
        chk({name, ":done_cycle"}, c, n + PIPE);
      end else begin
        if (busy) bcnt++;
        @(posedge clk); #1;
        c++;
      end
    end
    chk({name, ":done_reached"}, seen, 1'b1);
    chk({name, ":busy_cycles"}, bcnt, n + PIPE);
    chk({name, ":busy_in_done"}, busy, 1'b0);
    chk({name, ":err_cnt"}, err_cnt, e_err);
    chk({name, ":first_fail"}, first_fail, e_first);
    chk({name, ":pass"}, pass, e_pass);
  endtask

  typedef struct {
    logic        mode;
    logic [15:0] cnt;
    logic [63:0] mask;
    int          e_err;
    int          e_first;
    logic        e_pass;
  } vec_t;

  vec_t tbl [7];

  initial begin
    tbl[0] = '{1'b0, 16'd0,  64'h0,                     0, 0,  1'b1};
    tbl[1] = '{1'b0, 16'd0,  64'h20,                    1, 5,  1'b0};
    tbl[2] = '{1'b1, 16'd20, 64'h0,                     0, 0,  1'b1};
    tbl[3] = '{1'b1, 16'd0,  64'hFFFF_FFFF_FFFF_FFFF,   0, 0,  1'b1};
    tbl[4] = '{1'b1, 16'd20, 64'h2_0008,                2, 3,  1'b0};
    tbl[5] = '{1'b0, 16'd7,  64'h10_8000,               1, 15, 1'b0};
    tbl[6] = '{1'b1, 16'd1,  64'h1,                     1, 0,  1'b0};

    rst_n = 0; start = 0; mode = 0; count = 0; exp_v = 0;
    rst2_n = 0; start2 = 0; mode2 = 0; count2 = 0; resp2 = 8'h00; exp2 = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst:stim", stim, 0);
    chk("rst:busy", busy, 0);
    chk("rst:done", done, 0);
    chk("rst:pass", pass, 0);
    chk("rst:err", err_cnt, 0);
    chk("rst:first", first_fail, 0);
    chk("rst2:err", err2, 0);
    @(negedge clk);
    rst_n = 1; rst2_n = 1;
    @(posedge clk); #1;

    // Table-driven runs
    for (int i = 0; i < 7; i++)
      run($sformatf("tbl%0d", i), tbl[i].mode, tbl[i].cnt, tbl[i].mask,
          tbl[i].e_err, tbl[i].e_first, tbl[i].e_pass);

    // Randomized runs against the reference model
    for (int r = 0; r < 10; r++) begin
      logic        m;
      logic [15:0] cnt;
      logic [63:0] mask;
      int          ee, ef;
      logic        ep;
      m    = 1'($urandom % 2);
      cnt  = 16'($urandom_range(0, 40));
      mask = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      ref_model(m, cnt, mask, ee, ef, ep);
      run($sformatf("rnd%0d", r), m, cnt, mask, ee, ef, ep);
    end

    // Saturation with ERRW = 2, every vector mismatching, mid-run START ignored
    begin
      int  c, bcnt;
      bit  seen;
      c = 0; bcnt = 0; seen = 0;
      mode2 = 0;
      start2 = 1;
      @(posedge clk); #1;
      start2 = 0;
      while (!seen && c < 40) begin
        start2 = (c == 5);
        if (c < 16) chk($sformatf("sat:stim%0d", c), stim2, c);
        if (done2) begin
          seen = 1;
        end else begin
          if (busy2) bcnt++;
          @(posedge clk); #1;
          c++;
        end
      end
      start2 = 0;
      chk("sat:done_reached", seen, 1'b1);
      chk("sat:busy_cycles", bcnt, 16 + PIPE);
      chk("sat:err_cnt", err2, 2'd3);
      chk("sat:first_fail", ff2, 0);
      chk("sat:pass", pass2, 0);
    end

    // Mid-run reset at vector 7, with errors injected on vectors 0..3 beforehand
    begin
      mode = 0;
      start = 1;
      @(posedge clk); #1;
      start = 0;
      for (int c = 0; c < 7; c++) begin
        if (c >= PIPE) exp_v = golden(4'(c - PIPE)) ^ ((c - PIPE < 4) ? 8'h01 : 8'h00);
        else exp_v = '0;
        @(posedge clk); #1;
      end
      chk("mrst:stim7", stim, 4'd7);
      chk("mrst:err_before", err_cnt, 4);
      #2;
      rst_n = 0;
      #1;
      chk("mrst:stim", stim, 0);
      chk("mrst:busy", busy, 0);
      chk("mrst:done", done, 0);
      chk("mrst:pass", pass, 0);
      chk("mrst:err", err_cnt, 0);
      chk("mrst:first", first_fail, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      @(posedge clk); #1;
      run("post_rst", 1'b0, 16'd0, 64'h0, 0, 0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

endmodule
